// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start bit, 4 data bits LSB first, even-parity bit, stop bit.
// Each bit is held for CLKS_PER_BIT cycles. Nibbles arrive over a valid/ready handshake.
module parity_frame_tx #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx_out,
  output logic       busy,
  output logic       parity_out,
  output logic       frame_done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [1:0]       bit_q, bit_d;
  logic [3:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             parity_q, parity_d;
  logic             done_q, done_d;
  logic             bit_end;

  assign bit_end = (cyc_q == CNT_LAST);

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    parity_d = parity_q;
    done_d   = 1'b0;

    if (state_q != IDLE) begin
      cyc_d = bit_end ? '0 : cyc_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (valid_in) begin
          shift_d  = data_in;
          parity_d = ^data_in;
          state_d  = START;
          tx_d     = 1'b0;
          busy_d   = 1'b1;
          cyc_d    = '0;
          bit_d    = 2'd0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          bit_d   = 2'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 2'd3) begin
            state_d = PARITY;
            tx_d    = parity_q;
          end else begin
            // Next data bit is the one moving into position 0
            shift_d = {1'b0, shift_q[3:1]};
            bit_d   = bit_q + 2'd1;
            tx_d    = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        cyc_d   = '0;
        bit_d   = 2'd0;
      end
    endcase
  end

  // State register; reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cyc_q    <= '0;
      bit_q    <= 2'd0;
      shift_q  <= 4'd0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      parity_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      parity_q <= parity_d;
      done_q   <= done_d;
    end
  end

  assign ready_out  = (state_q == IDLE);
  assign tx_out     = tx_q;
  assign busy       = busy_q;
  assign parity_out = parity_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Directed bench for parity_frame_tx at N=4 and N=1, with a scoreboard of expected line bits.
module tb_parity_frame_tx;

  logic       clk;
  logic       rst;
  logic [3:0] data_in;
  logic       valid_in;

  logic rdy4, tx4, busy4, par4, done4;
  logic rdy1, tx1, busy1, par1, done1;

  logic sel;
  logic rdy, tx, bsy, par, done;

  int checks;
  int failures;
  int cyc;

  logic exp_bits[$];
  logic exp_par[$];

  parity_frame_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .ready_out(rdy4), .tx_out(tx4), .busy(busy4), .parity_out(par4), .frame_done(done4)
  );

  parity_frame_tx #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .ready_out(rdy1), .tx_out(tx1), .busy(busy1), .parity_out(par1), .frame_done(done1)
  );

  assign rdy  = sel ? rdy1  : rdy4;
  assign tx   = sel ? tx1   : tx4;
  assign bsy  = sel ? busy1 : busy4;
  assign par  = sel ? par1  : par4;
  assign done = sel ? done1 : done4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model of one frame on the line: start, d0..d3, parity (odd ones count), stop
  task automatic push_frame(input logic [3:0] d);
    int ones;
    ones = 0;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 4; i++) begin
      exp_bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    exp_bits.push_back((ones % 2) == 1);
    exp_bits.push_back(1'b1);
    exp_par.push_back((ones % 2) == 1);
  endtask

  task automatic accept(input logic [3:0] d, input bit track, input string tag);
    int budget;
    budget = 0;
    while (rdy !== 1'b1 && budget < 100) begin
      step();
      budget++;
    end
    chk($sformatf("%s_ready", tag), rdy, 1'b1);
    data_in  = d;
    valid_in = 1'b1;
    if (track) push_frame(d);
    step();
    valid_in = 1'b0;
  endtask

  // Called #1 after the accept edge; leaves off #1 after the edge that ends the frame
  task automatic run_frame(input string tag, input int pulse_at, input logic [3:0] pulse_d);
    int   n;
    logic b;
    logic p;
    n = sel ? 1 : 4;
    b = 1'b1;
    p = exp_par.pop_front();
    for (int j = 0; j < 7 * n; j++) begin
      if (j % n == 0) b = exp_bits.pop_front();
      if (pulse_at >= 0 && j == pulse_at) begin
        valid_in = 1'b1;
        data_in  = pulse_d;
      end else if (pulse_at >= 0 && j == pulse_at + 1) begin
        valid_in = 1'b0;
      end
      chk($sformatf("%s_tx_c%0d", tag, j), tx, b);
      chk($sformatf("%s_busy_c%0d", tag, j), bsy, 1'b1);
      chk($sformatf("%s_ready_c%0d", tag, j), rdy, 1'b0);
      chk($sformatf("%s_done_c%0d", tag, j), done, 1'b0);
      chk($sformatf("%s_par_c%0d", tag, j), par, p);
      step();
    end
    chk($sformatf("%s_end_tx", tag), tx, 1'b1);
    chk($sformatf("%s_end_busy", tag), bsy, 1'b0);
    chk($sformatf("%s_end_done", tag), done, 1'b1);
    chk($sformatf("%s_end_ready", tag), rdy, 1'b1);
    chk($sformatf("%s_end_par", tag), par, p);
  endtask

  initial begin
    int a1;
    int a2;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    sel      = 1'b0;
    rst      = 1'b1;
    valid_in = 1'b1;
    data_in  = 4'b1111;

    // Reset held two cycles with valid high: reset must win
    step();
    step();
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", bsy, 1'b0);
    chk("rst_ready", rdy, 1'b1);
    chk("rst_par", par, 1'b0);
    chk("rst_done", done, 1'b0);
    rst      = 1'b0;
    valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("idle_tx_%0d", i), tx, 1'b1);
      chk($sformatf("idle_busy_%0d", i), bsy, 1'b0);
      chk($sformatf("idle_ready_%0d", i), rdy, 1'b1);
      chk($sformatf("idle_done_%0d", i), done, 1'b0);
    end

    // Single frames at N=4
    accept(4'b0111, 1'b1, "f0111");
    run_frame("f0111", -1, 4'b0000);
    step();
    chk("f0111_done_drop", done, 1'b0);

    accept(4'b0000, 1'b1, "f0000");
    run_frame("f0000", -1, 4'b0000);

    accept(4'b1001, 1'b1, "f1001");
    run_frame("f1001", -1, 4'b0000);

    // valid pulse during the PARITY state must be ignored
    accept(4'b0011, 1'b1, "f0011");
    run_frame("f0011", 21, 4'b1111);
    step();
    chk("f0011_no_reaccept_busy", bsy, 1'b0);
    chk("f0011_no_reaccept_tx", tx, 1'b1);

    // Reset during DATA bit 2 of an untracked frame
    accept(4'b0110, 1'b0, "abort");
    for (int i = 0; i < 13; i++) step();
    chk("abort_mid_d2", tx, 1'b1);
    chk("abort_mid_busy", bsy, 1'b1);
    rst = 1'b1;
    step();
    chk("abort_tx", tx, 1'b1);
    chk("abort_busy", bsy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_ready", rdy, 1'b1);
    chk("abort_par", par, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("abort_quiet_done_%0d", i), done, 1'b0);
      chk($sformatf("abort_quiet_tx_%0d", i), tx, 1'b1);
    end
    accept(4'b1010, 1'b1, "f1010");
    run_frame("f1010", -1, 4'b0000);

    // Back-to-back at N=1 with valid held high
    for (int i = 0; i < 4; i++) step();
    sel = 1'b1;
    chk("n1_idle_ready", rdy, 1'b1);
    data_in  = 4'b1110;
    valid_in = 1'b1;
    push_frame(4'b1110);
    step();
    a1 = cyc;
    data_in = 4'b0001;
    push_frame(4'b0001);
    run_frame("b2b_1110", -1, 4'b0000);
    step();
    a2 = cyc;
    valid_in = 1'b0;
    chk_int("b2b_accept_gap", a2 - a1, 8);
    run_frame("b2b_0001", -1, 4'b0000);
    step();
    chk("b2b_done_drop", done, 1'b0);
    chk_int("scoreboard_empty", exp_bits.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parity_frame_tx.md
# parity_frame_tx

Serial frame transmitter that sequences a 4-bit nibble through the team's even-parity function and shifts it out on a single line. Each frame is start bit, 4 data bits (LSB first), parity bit, stop bit. The parity bit is 1 when the nibble has an odd number of ones, so every frame's data-plus-parity count is even. Sits between a nibble producer (valid/ready handshake) and the serial link toward the board pins or the matching receiver.

## Interface
- CLKS_PER_BIT, default 4: clock cycles each serial bit is held on tx_out; legal range 1..255.
- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- data_in  input  4  nibble to send; sampled only on an accepted handshake.
- valid_in  input  1  producer has a nibble on data_in.
- ready_out  output  1  block can accept a nibble; equals (state == IDLE).
- tx_out  output  1  serial line, registered; idles high.
- busy  output  1  frame in progress (state != IDLE), registered.
- parity_out  output  1  parity bit of the most recently accepted nibble: ^data latched.
- frame_done  output  1  one-cycle pulse on the cycle the stop bit completes.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. Internal registers:
  - bit counter (2 bits, data index 0..3);
  - cycle counter (width clog2(CLKS_PER_BIT), min 1);
  - shift register (4 bits).
- Reset (any state, any cycle): next edge forces state=IDLE, tx_out=1, busy=0, parity_out=0, frame_done=0, counters=0. Any in-flight frame is aborted and its data discarded. No partial stop bit.
- Accept: rising edge with valid_in=1 and ready_out=1 (and rst=0).
  - Latch data_in into the shift register.
  - Set parity_out = data_in[0]^data_in[1]^data_in[2]^data_in[3].
  - Set state=START, tx_out=0, busy=1, cycle counter=0.
- valid_in while busy is ignored. data_in changes after acceptance do not affect the frame.
- Each state holds tx_out for exactly CLKS_PER_BIT cycles. The cycle counter counts 0..CLKS_PER_BIT-1, then advances the state and resets.
- START → DATA: tx_out = shift[0].
- DATA: after each bit period, shift right and increment the bit counter. After bit index 3, go to PARITY with tx_out=parity_out.
- PARITY → STOP: tx_out=1.
- STOP end: state=IDLE, tx_out stays 1, busy=0, frame_done=1 for that one cycle.
- Parity is computed internally. It does not depend on the data bits already shifted out.

## Timing
- Accept at edge k: tx_out=0 from edge k.
  - Data bit i is driven from edge k+(1+i)·N (N=CLKS_PER_BIT).
  - Parity bit from k+5N; stop bit from k+6N.
  - IDLE and frame_done from k+7N.
- frame_done is high for exactly the cycle after edge k+7N.
- ready_out rises with IDLE at edge k+7N. The earliest next accept is edge k+7N+1. Minimum frame-to-frame period is 7N+1 cycles, with tx_out high for at least 1 cycle between frames.
- rst and valid_in at the same edge: reset wins, nothing is accepted.
- rst deasserted: IDLE with ready_out=1 in the first cycle after the last reset edge.
- N=1 is legal: each bit is one cycle, and the frame is 7 cycles.
- No combinational path from inputs to tx_out. ready_out is decoded from state only.

## Test plan
- Reset then idle, N=4: rst high 2 cycles → tx_out=1, busy=0, ready_out=1, parity_out=0, frame_done=0, and they hold with valid_in=0.
- Single frame, N=4, data_in=4'b0111 → tx_out sequence 0,1,1,1,0,1,1 (start, d0..d3, parity=1, stop), each held 4 cycles. parity_out=1. frame_done pulses at accept+28. Then ready_out=1.
- Even-weight data, N=4: 4'b0000 → parity bit 0. 4'b1001 → bits 0,1,0,0,1,0,1 and parity_out=0.
- Back-to-back, N=1: valid_in held high with 4'b1110 then 4'b0001 → first frame 0,0,1,1,1,1,1; one idle-high cycle; second frame 0,1,0,0,0,1,1. Accepts are 8 cycles apart.
- Reset mid-frame, N=4: assert rst during DATA bit 2 → next edge tx_out=1, busy=0, no frame_done pulse. The next accepted nibble 4'b1010 transmits cleanly with parity 0.
- Busy-ignore: pulse valid_in with 4'b1111 during the PARITY state of a 4'b0011 frame → no effect. The frame completes unchanged, and ready_out returns only after STOP.
